// File: rtl/io_uart_responder_pkg.sv
// Shared definitions for the I/O-window UART responder.
// Contents: register-select codes, TX FSM state encoding, and a width helper
// used to size the baud counter.
package io_uart_responder_pkg;

  // Register selects (cpumc_a[2:0]) within the I/O window
  localparam logic [2:0] IoSelUart = 3'd0;
  localparam logic [2:0] IoSelDone = 3'd4;
  localparam logic [2:0] IoSelStat = 3'd5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // $clog2 that never returns 0, so a counter always has at least one bit
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/io_uart_responder_sync_fifo.sv
// Synchronous show-ahead FIFO used as the UART transmit queue.
// Ports:
//   clk   in   clock, rising edge
//   rstn  in   synchronous active-low reset; empties the FIFO
//   push  in   write din (ignored when full)
//   din   in   WIDTH-bit write data
//   pop   in   drop the head entry (ignored when empty)
//   full  out  count == 2**DEPTH_LOG2
//   empty out  count == 0
//   dout  out  head entry, valid while not empty
module io_uart_responder_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [Depth];
  // One extra pointer bit distinguishes full from empty when the indices match
  logic [DEPTH_LOG2:0] wr_ptr_q;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic                do_push;
  logic                do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign dout = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/io_uart_responder.sv
// CPU I/O-window responder: decodes the register select, queues sel-0 writes
// into a TX FIFO and serialises them as UART 8N1, exposes a status byte and a
// sticky program-done flag.
// Ports:
//   clk_in        in   system clock, rising edge
//   rstn_in       in   synchronous active-low reset
//   io_en_in      in   I/O window selected
//   io_sel_in     in   register select
//   io_wr_in      in   1 = write, 0 = read
//   io_din_in     in   write data
//   io_dout_out   out  registered read data (1-cycle latency, holds otherwise)
//   stall_out     out  combinational back-pressure for sel-0 writes into a full FIFO
//   tx_out        out  UART serial line, idles high
//   prog_done_out out  sticky flag set by a sel-4 write
module io_uart_responder
  import io_uart_responder_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ    = 90000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       io_en_in,
  input  logic [2:0] io_sel_in,
  input  logic       io_wr_in,
  input  logic [7:0] io_din_in,
  output logic [7:0] io_dout_out,
  output logic       stall_out,
  output logic       tx_out,
  output logic       prog_done_out
);

  localparam int unsigned Div   = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned BaudW = clog2_min1(Div);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(Div - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]       dout_q;
  logic             prog_done_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_push;
  logic       fifo_pop;

  logic       uart_wr;
  logic       baud_done;
  logic       tx_busy_n;
  logic       tx_bit;
  logic [7:0] rd_data;

  // Address decode and back-pressure
  assign uart_wr   = io_en_in & io_wr_in & (io_sel_in == IoSelUart);
  assign stall_out = uart_wr & fifo_full;
  assign fifo_push = uart_wr & ~fifo_full;

  io_uart_responder_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rstn  (rstn_in),
    .push  (fifo_push),
    .din   (io_din_in),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_head)
  );

  assign baud_done = (baud_cnt_q == BaudLast);
  assign tx_busy_n = fifo_empty & (state_q == StIdle);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_done ? '0 : baud_cnt_q + 1'b1;
    fifo_pop   = 1'b0;
    tx_bit     = 1'b1;
    case (state_q)
      StIdle: begin
        tx_bit     = 1'b1;
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = 3'd0;
          state_d   = StStart;
        end
      end
      StStart: begin
        tx_bit = 1'b0;
        if (baud_done) state_d = StData;
      end
      StData: begin
        tx_bit = shift_q[0];
        if (baud_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        tx_bit = 1'b1;
        if (baud_done) begin
          // Chain straight into the next frame when more data is queued
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            bit_cnt_d = 3'd0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign tx_out = tx_bit;

  // Read mux; only the status register returns non-zero data
  always_comb begin
    rd_data = 8'h00;
    case (io_sel_in)
      IoSelStat: rd_data = {6'b0, tx_busy_n, fifo_full};
      default:   rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      dout_q      <= 8'h00;
      prog_done_q <= 1'b0;
    end else begin
      if (io_en_in && !io_wr_in) dout_q <= rd_data;
      if (io_en_in && io_wr_in && (io_sel_in == IoSelDone)) prog_done_q <= 1'b1;
    end
  end

  assign io_dout_out   = dout_q;
  assign prog_done_out = prog_done_q;

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed self-checking bench for io_uart_responder (DIV = 8, FIFO depth 4).
module tb_io_uart_responder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       io_en = 1'b0;
  logic [2:0] io_sel = 3'd0;
  logic       io_wr = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;
  logic       stall;
  logic       tx;
  logic       prog_done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_acc = 0;

  // Receiver capture
  logic [7:0] rx_bytes [$];
  logic       rx_stops [$];
  int         rx_starts [$];
  int         rx_st;
  logic [7:0] rx_b;

  io_uart_responder #(
    .SYS_CLK_FREQ    (8),
    .BAUD_RATE       (1),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk_in        (clk),
    .rstn_in       (rstn),
    .io_en_in      (io_en),
    .io_sel_in     (io_sel),
    .io_wr_in      (io_wr),
    .io_din_in     (io_din),
    .io_dout_out   (io_dout),
    .stall_out     (stall),
    .tx_out        (tx),
    .prog_done_out (prog_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [7:0] data, output bit stalled);
    int waitc;
    stalled = 1'b0;
    waitc   = 0;
    @(negedge clk);
    io_en  = 1'b1;
    io_wr  = 1'b1;
    io_sel = sel;
    io_din = data;
    #1;
    while (stall && waitc < 200) begin
      stalled = 1'b1;
      @(negedge clk);
      #1;
      waitc++;
    end
    if (waitc >= 200) check_eq("stall_timeout", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    last_acc = cyc;
    io_en = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] sel);
    @(negedge clk);
    io_en  = 1'b1;
    io_wr  = 1'b0;
    io_sel = sel;
    @(posedge clk);
    #1;
    io_en = 1'b0;
  endtask

  // UART receiver: samples mid-bit on negedges
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        rx_st = cyc;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          rx_b[i] = tx;
        end
        repeat (8) @(negedge clk);
        rx_bytes.push_back(rx_b);
        rx_stops.push_back(tx);
        rx_starts.push_back(rx_st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         s;
    int         first_stall;
    int         waitc;
    bit         low_seen;
    logic [9:0] frame;

    // 1. Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_tx", {31'b0, tx}, 32'd1);
    check_eq("rst_dout", {24'b0, io_dout}, 32'h00);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_prog_done", {31'b0, prog_done}, 32'd0);
    bus_read(3'd5);
    check_eq("stat_idle", {24'b0, io_dout}, 32'h02);
    bus_read(3'd0);
    check_eq("sel0_read", {24'b0, io_dout}, 32'h00);
    bus_read(3'd5);
    bus_read(3'd7);
    check_eq("sel7_read", {24'b0, io_dout}, 32'h00);
    bus_read(3'd5);
    repeat (5) @(posedge clk);
    #1;
    check_eq("dout_hold", {24'b0, io_dout}, 32'h02);

    // 2. Single frame 0xA5, exact bit timing
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(3'd0, 8'hA5, s);
    @(posedge clk);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      check_eq($sformatf("tx_a5_c%0d", k), {31'b0, tx}, {31'b0, frame[k / 8]});
    end
    @(negedge clk);
    check_eq("tx_a5_idle_after", {31'b0, tx}, 32'd1);
    repeat (10) @(posedge clk);

    // 3. Status while busy, then idle
    bus_write(3'd0, 8'h41, s);
    bus_read(3'd5);
    check_eq("stat_busy", {24'b0, io_dout}, 32'h00);
    repeat (90) @(posedge clk);
    bus_read(3'd5);
    check_eq("stat_done", {24'b0, io_dout}, 32'h02);

    // 4. Six back-to-back writes with back-pressure
    rx_bytes.delete();
    rx_stops.delete();
    rx_starts.delete();
    first_stall = 0;
    for (int i = 1; i <= 6; i++) begin
      bus_write(3'd0, 8'(i), s);
      if (s && first_stall == 0) first_stall = i;
    end
    check_eq("first_stall_write", first_stall, 32'd6);
    waitc = 0;
    while (rx_bytes.size() < 6 && waitc < 800) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("rx_count", rx_bytes.size(), 32'd6);
    if (rx_starts.size() >= 2)
      check_eq("stall_release", last_acc, rx_starts[1] + 1);
    for (int i = 0; i < rx_bytes.size() && i < 6; i++) begin
      check_eq($sformatf("rx_byte%0d", i), {24'b0, rx_bytes[i]}, i + 1);
      check_eq($sformatf("rx_stop%0d", i), {31'b0, rx_stops[i]}, 32'd1);
      if (i > 0)
        check_eq($sformatf("rx_gap%0d", i), rx_starts[i] - rx_starts[i-1], 32'd80);
    end
    repeat (20) @(posedge clk);

    // 5. Sticky program-done
    check_eq("prog_done_pre", {31'b0, prog_done}, 32'd0);
    bus_write(3'd4, 8'h00, s);
    check_eq("prog_done_set", {31'b0, prog_done}, 32'd1);
    bus_write(3'd0, 8'h5A, s);
    bus_read(3'd5);
    repeat (100) @(posedge clk);
    #1;
    check_eq("prog_done_sticky", {31'b0, prog_done}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("prog_done_rst", {31'b0, prog_done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    // 6. Reset mid-frame with two bytes queued
    bus_write(3'd0, 8'hC3, s);
    bus_write(3'd0, 8'h3C, s);
    bus_write(3'd0, 8'hFF, s);
    repeat (33) @(posedge clk);
    @(negedge clk);
    check_eq("tx_bit3_pre_rst", {31'b0, tx}, 32'd0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tx_after_rst", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    bus_read(3'd5);
    check_eq("stat_after_rst", {24'b0, io_dout}, 32'h02);
    low_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check_eq("no_frame_after_rst", {31'b0, low_seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
